mul_arb: RTL and testbench
==========================

MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameter: N, default 32, operand width of each multiplier input.
REQ-002 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid_i  in  2  per-requester request valid; bit k = requester k.
REQ-005 Port: req_ready_o  out  2  per-requester accept; at most one bit high per cycle.
REQ-006 Port: req0_a_i, req0_b_i  in  N each  requester 0 operands, unsigned.
REQ-007 Port: req1_a_i, req1_b_i  in  N each  requester 1 operands, unsigned.
REQ-008 Port: resp_valid_o  out  1  result valid.
REQ-009 Port: resp_ready_i  in  1  consumer accepts result.
REQ-010 Port: resp_id_o  out  1  requester index owning the result.
REQ-011 Port: resp_mul_o  out  2N  unsigned product.
REQ-012 Port: busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-013 The block SHALL share one unsigned N x N multiplier between two requesters, one operation in flight.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: req_ready_o[k] SHALL be high only for the granted requester k; all bits low in EXEC and RESP.
REQ-016 Grant SHALL be round-robin: a single valid requester wins; if both are valid, the requester named by the priority pointer wins.
REQ-017 After each accepted request, the pointer SHALL move to the requester that did not win; the pointer SHALL not move if no request is accepted.
REQ-018 On accept (valid & ready), operands and id SHALL register, and the FSM SHALL go IDLE->EXEC.
REQ-019 EXEC: the product SHALL register into resp_mul_o; the FSM SHALL go to RESP after the latency count expires.
REQ-020 Latency: with the accept at edge E0, resp_valid_o SHALL rise after edge E1 (default) and stay low before then.
REQ-021 RESP: resp_valid_o, resp_id_o and resp_mul_o SHALL stay stable until resp_ready_i is high at a clock edge.
REQ-022 RESP with resp_ready_i=1: the FSM SHALL go to IDLE; the next accept is possible one cycle later (no overlap).
REQ-023 Product SHALL be exact to full 2N bits, with no truncation; 0 operands SHALL give 0, and max x max SHALL give (2^N-1)^2.
REQ-024 Dropping req_valid_i without being accepted SHALL have no effect; no request SHALL be lost once accepted.

Reset
REQ-025 rst_ni low SHALL immediately force IDLE, pointer=0, resp_valid_o=0, resp_id_o=0, resp_mul_o=0, busy_o=0, req_ready_o=0 while asserted.
REQ-026 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no result SHALL appear after release.

Configuration
REQ-027 Macro MUL_ARB_PIPE_EN SHALL be the only compile-time option.
REQ-028 Without MUL_ARB_PIPE_EN: EXEC SHALL last one cycle, with result valid after E1.
REQ-029 With MUL_ARB_PIPE_EN: one extra product register stage SHALL be added, EXEC SHALL last two cycles (2-bit latency counter), and result SHALL be valid after E2; all other rules are unchanged.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE/EXEC/RESP) and the latency constants for both configurations.
REQ-031 The multiplier SHALL be a single sub-module instance, multu, with parameter N; the arbiter SHALL contain no multiply logic itself.

Verification
REQ-032 Single requester: req0 a=3, b=5 and resp_ready_i=1 SHALL give resp_mul_o=15 and id=0 one edge after accept (two with PIPE_EN).
REQ-033 Contention: both valid from reset SHALL grant 0 then 1, with products 6x7=42 (id 0) and 9x9=81 (id 1), in order.
REQ-034 Backpressure: resp_ready_i=0 for 5 cycles SHALL hold resp_valid_o=1 with stable data/id and req_ready_o=0.
REQ-035 Boundary, N=32: 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFE00000001, and 0 x 0xFFFFFFFF SHALL give 0.
REQ-036 Reset in EXEC: rst_ni low for 1 cycle SHALL leave resp_valid_o=0 afterward, with the next request granted to req0.
REQ-037 Fairness: both valid continuously for 10 ops SHALL give grants that alternate 0,1,0,1,...

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared definitions for the mul_arb shared-multiplier arbiter.
// Compile-time option: MUL_ARB_PIPE_EN adds one product register stage.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of EXEC cycles for each build flavour
    localparam logic [1:0] LAT_BASE = 2'd1;
    localparam logic [1:0] LAT_PIPE = 2'd2;

`ifdef MUL_ARB_PIPE_EN
    localparam logic [1:0] LAT_CYCLES = LAT_PIPE;
`else
    localparam logic [1:0] LAT_CYCLES = LAT_BASE;
`endif

endpackage

// File: rtl/mul_arb_multu.sv
// Unsigned N x N combinational multiplier producing the full 2N-bit product.
module multu #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    // Zero-extend both operands so the product is evaluated at full width
    assign p_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};

endmodule

// File: rtl/mul_arb.sv
// Two-requester round-robin arbiter sharing one unsigned multiplier,
// one operation in flight. Define MUL_ARB_PIPE_EN for an extra product stage.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [1:0]     req_valid_i,
    output logic [1:0]     req_ready_o,
    input  logic [N-1:0]   req0_a_i,
    input  logic [N-1:0]   req0_b_i,
    input  logic [N-1:0]   req1_a_i,
    input  logic [N-1:0]   req1_b_i,
    output logic           resp_valid_o,
    input  logic           resp_ready_i,
    output logic           resp_id_o,
    output logic [2*N-1:0] resp_mul_o,
    output logic           busy_o
);

    state_e         state_q;
    logic           ptr_q;
    logic [N-1:0]   op_a_q;
    logic [N-1:0]   op_b_q;
    logic           id_q;
    logic [1:0]     cnt_q;
    logic           resp_valid_q;
    logic           resp_id_q;
    logic [2*N-1:0] resp_mul_q;
    logic           busy_q;

    logic           gnt_any;
    logic           gnt_id;
    logic           accept;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic [2*N-1:0] mul_d;
    logic [2*N-1:0] result;

    multu #(.N(N)) u_multu (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mul_d)
    );

`ifdef MUL_ARB_PIPE_EN
    logic [2*N-1:0] prod_pipe_q;

    // Extra product stage, loaded while the operation is executing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_pipe_q <= '0;
        end else if (state_q == ST_EXEC) begin
            prod_pipe_q <= mul_d;
        end
    end

    assign result = prod_pipe_q;
`else
    assign result = mul_d;
`endif

    // Round-robin grant; ready is only offered while idle and out of reset
    always_comb begin
        gnt_any     = 1'b0;
        gnt_id      = 1'b0;
        req_ready_o = '0;
        unique case (req_valid_i)
            2'b01:   begin gnt_any = 1'b1; gnt_id = 1'b0;  end
            2'b10:   begin gnt_any = 1'b1; gnt_id = 1'b1;  end
            2'b11:   begin gnt_any = 1'b1; gnt_id = ptr_q; end
            default: begin gnt_any = 1'b0; gnt_id = 1'b0;  end
        endcase
        if (rst_ni && (state_q == ST_IDLE) && gnt_any) begin
            req_ready_o[gnt_id] = 1'b1;
        end
    end

    assign accept = |(req_valid_i & req_ready_o);
    assign sel_a  = gnt_id ? req1_a_i : req0_a_i;
    assign sel_b  = gnt_id ? req1_b_i : req0_b_i;

    // Control FSM with registered response and status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_mul_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_a_q  <= sel_a;
                        op_b_q  <= sel_b;
                        id_q    <= gnt_id;
                        ptr_q   <= ~gnt_id;
                        cnt_q   <= LAT_CYCLES - 2'd1;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 2'd0) begin
                        resp_mul_q   <= result;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_mul_o   = resp_mul_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: transaction-level reference model,
// directed scenarios and randomized traffic. Honours MUL_ARB_PIPE_EN.
module tb_mul_arb;

    localparam int unsigned N = 32;
`ifdef MUL_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_ni;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [N-1:0]   a0, b0, a1, b1;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [2*N-1:0] resp_mul;
    logic           busy;

    mul_arb #(.N(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req0_a_i     (a0),
        .req0_b_i     (b0),
        .req1_a_i     (a1),
        .req1_b_i     (b1),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_mul_o   (resp_mul),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one transaction record plus a pending-result flag
    logic           m_ptr;
    logic           m_inflight;
    int             m_cnt;
    logic           m_pend;
    logic           m_id;
    logic [2*N-1:0] m_prod;
    int             grants[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] full_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned x, y;
        x = longint'(a);
        y = longint'(b);
        return 64'(x * y);
    endfunction

    // One clock: check outputs against the model, then advance the model
    task automatic cycle();
        logic [1:0] exp_rdy;
        logic       gid;
        logic       rr;
        logic [N-1:0] sa, sb;
        #1;
        exp_rdy = '0;
        gid     = 1'b0;
        if (!m_inflight && !m_pend) begin
            case (req_valid)
                2'b01: begin gid = 1'b0;  exp_rdy[0] = 1'b1; end
                2'b10: begin gid = 1'b1;  exp_rdy[1] = 1'b1; end
                2'b11: begin gid = m_ptr; exp_rdy[m_ptr] = 1'b1; end
                default: ;
            endcase
        end
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("busy", 64'(busy), 64'(m_inflight | m_pend));
        check_eq("resp_valid", 64'(resp_valid), 64'(m_pend));
        if (m_pend) begin
            check_eq("resp_id", 64'(resp_id), 64'(m_id));
            check_eq("resp_mul", resp_mul, m_prod);
        end
        rr = resp_ready;
        sa = gid ? a1 : a0;
        sb = gid ? b1 : b0;
        @(posedge clk);
        #1;
        if (exp_rdy != 2'b00) begin
            grants.push_back(int'(gid));
            m_ptr      = ~gid;
            m_inflight = 1'b1;
            m_cnt      = LAT;
            m_id       = gid;
            m_prod     = full_mul(sa, sb);
        end else if (m_inflight) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_inflight = 1'b0;
                m_pend     = 1'b1;
            end
        end else if (m_pend && rr) begin
            m_pend = 1'b0;
        end
    endtask

    // Reset for one clock with traffic present; outputs must clear at once
    task automatic do_reset();
        req_valid = 2'b11;
        rst_ni    = 1'b0;
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_id", 64'(resp_id), 64'd0);
        check_eq("rst_mul", resp_mul, 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_ready_hold", 64'(req_ready), 64'd0);
        rst_ni     = 1'b1;
        req_valid  = 2'b00;
        m_ptr      = 1'b0;
        m_inflight = 1'b0;
        m_cnt      = 0;
        m_pend     = 1'b0;
        m_id       = 1'b0;
        m_prod     = '0;
    endtask

    // Run until n more grants occur, bounded by a cycle budget
    task automatic run_grants(input int n, input int budget);
        int target;
        int k;
        target = grants.size() + n;
        k = 0;
        while (grants.size() < target && k < budget) begin
            cycle();
            k++;
        end
        check_eq("grant_budget", 64'(grants.size() >= target), 64'd1);
    endtask

    // Run until the DUT presents a result, bounded by a cycle budget
    task automatic run_to_resp(input int budget);
        int k;
        k = 0;
        while (!resp_valid && k < budget) begin
            cycle();
            k++;
        end
        check_eq("resp_budget", 64'(resp_valid), 64'd1);
    endtask

    initial begin
        int base;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rst_ni = 1'b0;
        @(negedge clk);
        do_reset();

        // Single requester 3 x 5
        a0 = 32'd3; b0 = 32'd5; req_valid = 2'b01; resp_ready = 1'b1;
        cycle();
        req_valid = 2'b00;
        run_to_resp(LAT + 2);
        check_eq("single_mul", resp_mul, 64'd15);
        check_eq("single_id", 64'(resp_id), 64'd0);
        repeat (3) cycle();

        // Contention from reset: 0 then 1
        do_reset();
        a0 = 32'd6; b0 = 32'd7; a1 = 32'd9; b1 = 32'd9;
        req_valid = 2'b11;
        base = grants.size();
        run_grants(1, 10);
        req_valid = 2'b10;
        run_to_resp(LAT + 2);
        check_eq("cont_mul0", resp_mul, 64'd42);
        run_grants(1, 10);
        req_valid = 2'b00;
        run_to_resp(LAT + 2);
        check_eq("cont_mul1", resp_mul, 64'd81);
        check_eq("cont_id1", 64'(resp_id), 64'd1);
        check_eq("cont_g0", 64'(grants[base]), 64'd0);
        check_eq("cont_g1", 64'(grants[base+1]), 64'd1);
        repeat (2) cycle();

        // Backpressure: result must hold for 5 cycles with ready low
        resp_ready = 1'b0;
        a1 = 32'd1234; b1 = 32'd5678; req_valid = 2'b10;
        run_grants(1, 10);
        req_valid = 2'b11;
        run_to_resp(LAT + 2);
        repeat (5) cycle();
        resp_ready = 1'b1;
        req_valid  = 2'b00;
        repeat (3) cycle();

        // Boundary operands
        a0 = '1; b0 = '1; req_valid = 2'b01;
        run_grants(1, 10);
        req_valid = 2'b00;
        run_to_resp(LAT + 2);
        check_eq("max_mul", resp_mul, 64'hFFFF_FFFE_0000_0001);
        cycle();
        a1 = '0; b1 = '1; req_valid = 2'b10;
        run_grants(1, 10);
        req_valid = 2'b00;
        run_to_resp(LAT + 2);
        check_eq("zero_mul", resp_mul, 64'd0);
        repeat (2) cycle();

        // Reset while executing: no result afterwards, req0 wins next
        a1 = 32'd77; b1 = 32'd3; req_valid = 2'b10;
        run_grants(1, 10);
        req_valid = 2'b00;
        check_eq("exec_busy", 64'(busy), 64'd1);
        do_reset();
        repeat (LAT + 3) cycle();
        a0 = 32'd11; b0 = 32'd13; a1 = 32'd17; b1 = 32'd19;
        req_valid = 2'b11;
        base = grants.size();
        run_grants(1, 10);
        check_eq("post_rst_grant", 64'(grants[base]), 64'd0);
        req_valid = 2'b00;
        run_to_resp(LAT + 2);
        repeat (2) cycle();

        // Fairness: both valid continuously for 10 operations
        do_reset();
        req_valid = 2'b11;
        base = grants.size();
        run_grants(10, 200);
        for (int i = 0; i < 10; i++) begin
            if (base + i < grants.size())
                check_eq("fair", 64'(grants[base+i]), 64'(i % 2));
        end
        req_valid = 2'b00;
        repeat (4) cycle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid  = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            a0 = ($urandom_range(0, 7) == 0) ? '1 : 32'($urandom);
            b0 = ($urandom_range(0, 7) == 0) ? '0 : 32'($urandom);
            a1 = 32'($urandom);
            b1 = ($urandom_range(0, 7) == 0) ? '1 : 32'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
